// File: rtl/add16_sched_pkg.sv
// add16_sched shared types and default sizes.
// The top and the arbiter import this package.
package add16_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_N_WORDS = 16;
  localparam int DEF_RES_W   = 16;
  localparam int DEF_CNT_W   = $clog2(DEF_N_WORDS);

endpackage

// File: rtl/add16_sched_rr_arbiter.sv
// Round-robin pick: scan the requests starting at i_ptr.
// Purely combinational; the caller registers the result.
module rr_arbiter
  import add16_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_any = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
        o_gnt[(int'(i_ptr) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add16_sched.sv
// Shared 16-word accumulator time-multiplexed between requesters.
// Grants round-robin, sums one frame, returns the sum tagged with its id.
module add16_sched
  import add16_sched_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_WORDS = DEF_N_WORDS,
  parameter int RES_W   = DEF_RES_W,
  parameter int N_REQ   = 2,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RES_W-1:0]        res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(N_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_grant;
  logic [N_REQ-1:0]  r_gnt_oh;
  logic [ID_W-1:0]   r_ptr;
  logic [RES_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic [DATA_W-1:0] w_word;
  logic              w_accept;
  logic              w_last;
  logic              w_start;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  assign w_word   = req_data[int'(r_grant)*DATA_W +: DATA_W];
  assign w_accept = (r_state == S_ACCUM) && req_valid[r_grant];
  assign w_last   = (r_cnt == CNT_W'(N_WORDS - 1));
  assign w_start  = (r_state == S_IDLE) && w_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ACCUM;
      S_ACCUM: if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pointer moves to the slot after the winner so it goes last next time.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant  <= '0;
      r_gnt_oh <= '0;
      r_ptr    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_grant  <= w_idx;
      r_gnt_oh <= w_gnt;
      r_ptr    <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc <= r_acc + RES_W'(w_word);
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req_ready = (r_state == S_ACCUM) ? r_gnt_oh : '0;
  assign res_valid = (r_state == S_DONE);
  assign res_data  = r_acc;
  assign res_id    = r_grant;
  assign busy      = (r_state != S_IDLE);

endmodule
